// File: rtl/aximm_resp_pkg.sv
// Shared response/burst encodings and FSM state types for the follower memory responder.
package aximm_resp_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/aximm_follower_mem_responder_if.sv
// F_user_* AXI-MM channels between the follower (master) and the memory responder (slave).
interface aximm_follower_mem_responder_if #(
  parameter int DATA_WIDTH = 64
);

  logic [3:0]            arid;
  logic [2:0]            arsize;
  logic [7:0]            arlen;
  logic [1:0]            arburst;
  logic [31:0]           araddr;
  logic                  arvalid;
  logic                  arready;

  logic [3:0]            awid;
  logic [2:0]            awsize;
  logic [7:0]            awlen;
  logic [1:0]            awburst;
  logic [31:0]           awaddr;
  logic                  awvalid;
  logic                  awready;

  logic [3:0]            wid;
  logic [DATA_WIDTH-1:0] wdata;
  logic [15:0]           wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [3:0]            rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  logic [3:0]            bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output arid, arsize, arlen, arburst, araddr, arvalid, input arready,
    output awid, awsize, awlen, awburst, awaddr, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input  rid, rdata, rlast, rresp, rvalid, output rready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, arsize, arlen, arburst, araddr, arvalid, output arready,
    input  awid, awsize, awlen, awburst, awaddr, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid, output wready,
    output rid, rdata, rlast, rresp, rvalid, input rready,
    output bid, bresp, bvalid, input bready
  );

endinterface

// File: rtl/aximm_follower_mem_responder_mem_bank.sv
// Word array with a byte-strobed synchronous write port and a combinational read port.
module aximm_mem_bank #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_AW     = 6
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [MEM_AW-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [MEM_AW-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [2**MEM_AW];

  // Not reset: contents survive a reset so abandoned partial bursts stay visible.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) begin
          mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/aximm_follower_mem_responder.sv
// Memory responder terminating the follower user channels: AW/W bursts write the bank,
// AR bursts read it back on R; read and write FSMs run independently.
module aximm_follower_mem_responder
  import aximm_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_AW     = 6
) (
  input  logic                         clk_wr,
  input  logic                         rst_wr,
  aximm_follower_mem_responder_if.slave user,
  output logic [15:0]                  wr_burst_cnt,
  output logic [15:0]                  rd_burst_cnt,
  output logic [7:0]                   err_cnt
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int BW = $clog2(NB);

  typedef logic [MEM_AW-1:0] idx_t;

  function automatic idx_t next_idx(idx_t idx, logic [1:0] burst);
    return (burst == FIXED) ? idx : idx + idx_t'(1);
  endfunction

  wr_state_t   wr_state_q, wr_state_d;
  logic [3:0]  wr_id_q, wr_id_d;
  logic [7:0]  wr_len_q, wr_len_d;
  logic [1:0]  wr_burst_q, wr_burst_d;
  idx_t        wr_idx_q, wr_idx_d;
  logic [7:0]  wr_beat_q, wr_beat_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;

  rd_state_t   rd_state_q, rd_state_d;
  logic [3:0]  rd_id_q, rd_id_d;
  logic [7:0]  rd_len_q, rd_len_d;
  logic [1:0]  rd_burst_q, rd_burst_d;
  idx_t        rd_idx_q, rd_idx_d;
  logic [7:0]  rd_beat_q, rd_beat_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;

  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        wr_last_by_len;
  logic [1:0]  err_inc;
  logic [8:0]  err_sum;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic        unused_ok;

  // Handshake outputs are forced low while reset is held, even before the flops clear.
  assign user.awready = awready_q & ~rst_wr;
  assign user.wready  = wready_q  & ~rst_wr;
  assign user.bvalid  = bvalid_q  & ~rst_wr;
  assign user.arready = arready_q & ~rst_wr;
  assign user.rvalid  = rvalid_q  & ~rst_wr;

  assign aw_hs = user.awvalid & user.awready;
  assign w_hs  = user.wvalid  & user.wready;
  assign b_hs  = user.bvalid  & user.bready;
  assign ar_hs = user.arvalid & user.arready;
  assign r_hs  = user.rvalid  & user.rready;

  assign user.bid   = wr_id_q;
  assign user.bresp = bresp_q;
  assign user.rid   = rd_id_q;
  assign user.rresp = rresp_q;
  assign user.rlast = rlast_q;
  assign user.rdata = mem_rdata;

  assign wr_burst_cnt = wr_cnt_q;
  assign rd_burst_cnt = rd_cnt_q;
  assign err_cnt      = err_cnt_q;

  assign unused_ok = ^{user.wid, user.arsize, user.awsize, user.araddr, user.awaddr, user.wstrb};

  aximm_mem_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_AW    (MEM_AW)
  ) u_bank (
    .clk  (clk_wr),
    .we   (w_hs),
    .waddr(wr_idx_q),
    .wdata(user.wdata),
    .wstrb(user.wstrb[NB-1:0]),
    .raddr(rd_idx_q),
    .rdata(mem_rdata)
  );

  assign wr_last_by_len = (wr_beat_q == wr_len_q);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    wr_len_d   = wr_len_q;
    wr_burst_d = wr_burst_q;
    wr_idx_d   = wr_idx_q;
    wr_beat_d  = wr_beat_q;
    bresp_d    = bresp_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          wr_id_d    = user.awid;
          wr_len_d   = user.awlen;
          wr_burst_d = user.awburst;
          wr_idx_d   = user.awaddr[MEM_AW+BW-1:BW];
          wr_beat_d  = '0;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          wr_idx_d  = next_idx(wr_idx_q, wr_burst_q);
          wr_beat_d = wr_beat_q + 8'd1;
          // Either an early wlast or reaching awlen closes the burst; disagreement is an error.
          if (user.wlast || wr_last_by_len) begin
            bresp_d    = ((user.wlast != wr_last_by_len) || (wr_burst_q == RSVD)) ? SLVERR : OKAY;
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            wr_state_d = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_id_d    = rd_id_q;
    rd_len_d   = rd_len_q;
    rd_burst_d = rd_burst_q;
    rd_idx_d   = rd_idx_q;
    rd_beat_d  = rd_beat_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_id_d    = user.arid;
          rd_len_d   = user.arlen;
          rd_burst_d = user.arburst;
          rd_idx_d   = user.araddr[MEM_AW+BW-1:BW];
          rd_beat_d  = '0;
          rresp_d    = (user.arburst == RSVD) ? SLVERR : OKAY;
          rlast_d    = (user.arlen == 8'd0);
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            rlast_d    = 1'b0;
            rvalid_d   = 1'b0;
            arready_d  = 1'b1;
            rd_state_d = RD_IDLE;
          end else begin
            rd_idx_d  = next_idx(rd_idx_q, rd_burst_q);
            rd_beat_d = rd_beat_q + 8'd1;
            rlast_d   = ((rd_beat_q + 8'd1) == rd_len_q);
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Every SLVERR-carrying handshake counts, B responses and R beats alike.
  always_comb begin
    wr_cnt_d  = wr_cnt_q + {15'd0, b_hs};
    rd_cnt_d  = rd_cnt_q + {15'd0, r_hs & rlast_q};
    err_inc   = {1'b0, b_hs & (bresp_q == SLVERR)} + {1'b0, r_hs & (rresp_q == SLVERR)};
    err_sum   = {1'b0, err_cnt_q} + {7'd0, err_inc};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      wr_state_q <= WR_IDLE;
      wr_id_q    <= '0;
      wr_len_q   <= '0;
      wr_burst_q <= '0;
      wr_idx_q   <= '0;
      wr_beat_q  <= '0;
      bresp_q    <= OKAY;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_id_q    <= '0;
      rd_len_q   <= '0;
      rd_burst_q <= '0;
      rd_idx_q   <= '0;
      rd_beat_q  <= '0;
      rresp_q    <= OKAY;
      rlast_q    <= 1'b0;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_len_q   <= wr_len_d;
      wr_burst_q <= wr_burst_d;
      wr_idx_q   <= wr_idx_d;
      wr_beat_q  <= wr_beat_d;
      bresp_q    <= bresp_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_len_q   <= rd_len_d;
      rd_burst_q <= rd_burst_d;
      rd_idx_q   <= rd_idx_d;
      rd_beat_q  <= rd_beat_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_aximm_follower_mem_responder.sv
// Bench for the follower memory responder: per-cycle channel/memory model plus directed bursts.
module tb_aximm_follower_mem_responder;

  localparam int DW = 64;

  logic        clk_wr = 1'b0;
  logic        rst_wr;
  logic [15:0] wr_burst_cnt, rd_burst_cnt;
  logic [7:0]  err_cnt;

  aximm_follower_mem_responder_if #(.DATA_WIDTH(DW)) user ();

  aximm_follower_mem_responder #(
    .DATA_WIDTH(DW),
    .MEM_AW    (6)
  ) dut (
    .clk_wr      (clk_wr),
    .rst_wr      (rst_wr),
    .user        (user),
    .wr_burst_cnt(wr_burst_cnt),
    .rd_burst_cnt(rd_burst_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  bit rnd_mode = 1'b0;

  always @(posedge clk_wr) cycle++;

  typedef struct { logic [63:0] data; logic [3:0] id; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bbeat_t;
  rbeat_t rq[$];
  bbeat_t bq[$];

  // Model state: channel phases, burst cursors, word store with known-byte mask.
  int          wph = 0, rph = 0;
  logic [3:0]  m_wid, m_rid;
  int          m_wlen, m_wbeat, m_widx, m_rlen, m_rbeat, m_ridx;
  logic [1:0]  m_wburst, m_rburst, m_bresp;
  int          m_wcnt = 0, m_rcnt = 0, m_err = 0;
  logic [63:0] mmem   [64];
  logic [63:0] mknown [64] = '{default: '0};
  bit          last_len;
  bit          pr_stall = 0, pb_stall = 0;
  logic [3:0]  p_rid, p_bid;
  logic [1:0]  p_rresp, p_bresp;
  logic        p_rlast;

  logic [63:0] t2d [4] = '{64'h6262_0000_1111_00A0, 64'h6363_0000_2222_00A1,
                           64'h0000_0000_3333_00A2, 64'h0101_0000_4444_00A3};
  logic [63:0] t5d [4] = '{64'h4848_DEAD_0000_0001, 64'h4949_BEEF_0000_0002,
                           64'h5050_CAFE_0000_0003, 64'h5151_F00D_0000_0004};

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
  endtask

  // Compare DUT against the model mid-cycle, then advance the model by this cycle's handshakes.
  always @(negedge clk_wr) begin
    if (rst_wr) begin
      checkOutput("rst_awready", user.awready, 1'b0);
      checkOutput("rst_wready",  user.wready,  1'b0);
      checkOutput("rst_bvalid",  user.bvalid,  1'b0);
      checkOutput("rst_arready", user.arready, 1'b0);
      checkOutput("rst_rvalid",  user.rvalid,  1'b0);
      wph = 0; rph = 0; m_wcnt = 0; m_rcnt = 0; m_err = 0;
      pr_stall = 0; pb_stall = 0;
    end else begin
      checkOutput("awready", user.awready, wph == 0);
      checkOutput("wready",  user.wready,  wph == 1);
      checkOutput("bvalid",  user.bvalid,  wph == 2);
      if (wph == 2) begin
        checkOutput("bid",   user.bid,   m_wid);
        checkOutput("bresp", user.bresp, m_bresp);
      end
      if (pb_stall && user.bvalid) begin
        checkOutput("bid_stable",   user.bid,   p_bid);
        checkOutput("bresp_stable", user.bresp, p_bresp);
      end
      checkOutput("arready", user.arready, rph == 0);
      checkOutput("rvalid",  user.rvalid,  rph == 1);
      if (rph == 1) begin
        checkOutput("rid",   user.rid,   m_rid);
        checkOutput("rlast", user.rlast, m_rbeat == m_rlen);
        checkOutput("rresp", user.rresp, (m_rburst == 2'b11) ? 2'b10 : 2'b00);
        checkOutput("rdata", user.rdata & mknown[m_ridx], mmem[m_ridx] & mknown[m_ridx]);
      end
      if (pr_stall && user.rvalid) begin
        checkOutput("rid_stable",   user.rid,   p_rid);
        checkOutput("rlast_stable", user.rlast, p_rlast);
        checkOutput("rresp_stable", user.rresp, p_rresp);
      end
      checkOutput("wr_burst_cnt", wr_burst_cnt, m_wcnt % 65536);
      checkOutput("rd_burst_cnt", rd_burst_cnt, m_rcnt % 65536);
      checkOutput("err_cnt",      err_cnt,      m_err);
      pb_stall = user.bvalid && !user.bready;
      p_bid = user.bid; p_bresp = user.bresp;
      pr_stall = user.rvalid && !user.rready;
      p_rid = user.rid; p_rresp = user.rresp; p_rlast = user.rlast;

      case (wph)
        0: if (user.awvalid) begin
          m_wid = user.awid; m_wlen = user.awlen; m_wburst = user.awburst;
          m_widx = (user.awaddr >> 3) % 64; m_wbeat = 0; wph = 1;
        end
        1: if (user.wvalid) begin
          for (int b = 0; b < 8; b++) begin
            if (user.wstrb[b]) begin
              mmem[m_widx][8*b +: 8]   = user.wdata[8*b +: 8];
              mknown[m_widx][8*b +: 8] = 8'hFF;
            end
          end
          last_len = (m_wbeat == m_wlen);
          if (user.wlast || last_len) begin
            m_bresp = ((user.wlast != last_len) || m_wburst == 2'b11) ? 2'b10 : 2'b00;
            wph = 2;
          end else begin
            m_wbeat++;
            if (m_wburst != 2'b00) m_widx = (m_widx + 1) % 64;
          end
        end
        default: if (user.bready) begin
          bq.push_back('{id: user.bid, resp: user.bresp});
          m_wcnt++;
          if (m_bresp == 2'b10 && m_err < 255) m_err++;
          wph = 0;
        end
      endcase

      if (rph == 0) begin
        if (user.arvalid) begin
          m_rid = user.arid; m_rlen = user.arlen; m_rburst = user.arburst;
          m_ridx = (user.araddr >> 3) % 64; m_rbeat = 0; rph = 1;
        end
      end else if (user.rready) begin
        rq.push_back('{data: user.rdata, id: user.rid, resp: user.rresp, last: user.rlast});
        if (m_rburst == 2'b11 && m_err < 255) m_err++;
        if (m_rbeat == m_rlen) begin
          m_rcnt++;
          rph = 0;
        end else begin
          m_rbeat++;
          if (m_rburst != 2'b00) m_ridx = (m_ridx + 1) % 64;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_wr); #1;
      user.rready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      user.bready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic sync();
    @(posedge clk_wr); #1;
  endtask

  task automatic sendAw(input logic [3:0] id, input logic [7:0] len, input logic [1:0] burst,
                        input logic [31:0] addr, output int hs_cycle);
    int  n  = 0;
    logic ok = 1'b0;
    user.awid = id; user.awlen = len; user.awburst = burst; user.awaddr = addr;
    user.awsize = 3'd3; user.awvalid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk_wr); ok = user.awready; hs_cycle = cycle;
      sync(); n++;
    end
    user.awvalid = 1'b0;
    checkOutput("aw_accept", ok, 1'b1);
  endtask

  task automatic sendAr(input logic [3:0] id, input logic [7:0] len, input logic [1:0] burst,
                        input logic [31:0] addr, output int hs_cycle);
    int  n  = 0;
    logic ok = 1'b0;
    user.arid = id; user.arlen = len; user.arburst = burst; user.araddr = addr;
    user.arsize = 3'd3; user.arvalid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk_wr); ok = user.arready; hs_cycle = cycle;
      sync(); n++;
    end
    user.arvalid = 1'b0;
    checkOutput("ar_accept", ok, 1'b1);
  endtask

  task automatic sendW(input logic [63:0] data, input logic [15:0] strb, input logic last);
    int  n  = 0;
    logic ok = 1'b0;
    user.wdata = data; user.wstrb = strb; user.wlast = last; user.wvalid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk_wr); ok = user.wready;
      sync(); n++;
    end
    user.wvalid = 1'b0;
    checkOutput("w_accept", ok, 1'b1);
  endtask

  task automatic waitR(input int n);
    int k = 0;
    while (rq.size() < n && k < 300) begin sync(); k++; end
    checkOutput("r_beats_arrived", rq.size() >= n, 1'b1);
  endtask

  task automatic waitB(input int n);
    int k = 0;
    while (bq.size() < n && k < 300) begin sync(); k++; end
    checkOutput("b_arrived", bq.size() >= n, 1'b1);
  endtask

  task automatic applyStimulus();
    int     c1, c2;
    rbeat_t r;
    bbeat_t b;

    // Single-beat write then read
    sendAw(4'd3, 8'd0, 2'b01, 32'h40, c1);
    sendW(64'hA5A5_A5A5_A5A5_A5A5, 16'h00FF, 1'b1);
    waitB(1);
    if (bq.size() > 0) begin
      b = bq.pop_front();
      checkOutput("t1_bid", b.id, 4'd3);
      checkOutput("t1_bresp", b.resp, 2'b00);
    end
    sendAr(4'd5, 8'd0, 2'b01, 32'h40, c2);
    waitR(1);
    if (rq.size() > 0) begin
      r = rq.pop_front();
      checkOutput("t1_rdata", r.data, 64'hA5A5_A5A5_A5A5_A5A5);
      checkOutput("t1_rid", r.id, 4'd5);
      checkOutput("t1_rlast", r.last, 1'b1);
      checkOutput("t1_rresp", r.resp, 2'b00);
    end
    @(negedge clk_wr);
    checkOutput("t1_wr_cnt", wr_burst_cnt, 16'd1);
    checkOutput("t1_rd_cnt", rd_burst_cnt, 16'd1);
    sync();

    // INCR burst rolling over the top of the array: words 62, 63, 0, 1
    sendAw(4'd1, 8'd3, 2'b01, 32'h1F0, c1);
    for (int k = 0; k < 4; k++) sendW(t2d[k], 16'h00FF, k == 3);
    waitB(1);
    if (bq.size() > 0) begin b = bq.pop_front(); checkOutput("t2_bresp", b.resp, 2'b00); end
    sendAr(4'd2, 8'd3, 2'b01, 32'h1F0, c2);
    waitR(4);
    for (int k = 0; k < 4 && rq.size() > 0; k++) begin
      r = rq.pop_front();
      checkOutput("t2_rdata", r.data, t2d[k]);
      checkOutput("t2_rlast", r.last, k == 3);
    end
    sendAr(4'd2, 8'd0, 2'b01, 32'h0, c2);
    waitR(1);
    if (rq.size() > 0) begin r = rq.pop_front(); checkOutput("t2_word0", r.data, t2d[2]); end

    // Partial strobe on a FIXED burst; strobe bits above the lane count are ignored
    sendAw(4'd0, 8'd0, 2'b01, 32'h28, c1);
    sendW(64'hFFFF_FFFF_FFFF_FFFF, 16'h00FF, 1'b1);
    waitB(1); void'(bq.pop_front());
    sendAw(4'd0, 8'd1, 2'b00, 32'h28, c1);
    sendW(64'h1111_1111_1111_1111, 16'h000F, 1'b0);
    sendW(64'h2222_2222_2222_2222, 16'hF00F, 1'b1);
    waitB(1);
    if (bq.size() > 0) begin b = bq.pop_front(); checkOutput("t3_bresp", b.resp, 2'b00); end
    sendAr(4'd0, 8'd0, 2'b01, 32'h28, c2);
    waitR(1);
    if (rq.size() > 0) begin r = rq.pop_front(); checkOutput("t3_rdata", r.data, 64'hFFFF_FFFF_2222_2222); end

    // Early wlast on a 4-beat burst, then a reserved-burst read
    sendAw(4'd6, 8'd3, 2'b01, 32'hA0, c1);
    sendW(64'h0000_0000_0000_0020, 16'h00FF, 1'b0);
    sendW(64'h0000_0000_0000_0021, 16'h00FF, 1'b1);
    waitB(1);
    if (bq.size() > 0) begin
      b = bq.pop_front();
      checkOutput("t4_bid", b.id, 4'd6);
      checkOutput("t4_bresp", b.resp, 2'b10);
    end
    @(negedge clk_wr);
    checkOutput("t4_err_cnt", err_cnt, 8'd1);
    sync();
    sendAr(4'd4, 8'd2, 2'b11, 32'hA0, c2);
    waitR(3);
    for (int k = 0; k < 3 && rq.size() > 0; k++) begin
      r = rq.pop_front();
      checkOutput("t4_rresp", r.resp, 2'b10);
    end
    // Missing wlast at the awlen beat is also an error
    sendAw(4'd2, 8'd1, 2'b01, 32'hB0, c1);
    sendW(64'h0000_0000_0000_0030, 16'h00FF, 1'b0);
    sendW(64'h0000_0000_0000_0031, 16'h00FF, 1'b0);
    waitB(1);
    if (bq.size() > 0) begin b = bq.pop_front(); checkOutput("t4b_bresp", b.resp, 2'b10); end

    // Backpressure with AR and AW presented together
    rnd_mode = 1'b1;
    fork
      sendAr(4'd7, 8'd3, 2'b01, 32'h1F0, c2);
      begin
        sendAw(4'd9, 8'd3, 2'b01, 32'h180, c1);
        for (int k = 0; k < 4; k++) sendW(t5d[k], 16'h00FF, k == 3);
      end
    join
    checkOutput("t5_same_cycle", c2, c1);
    waitR(4);
    for (int k = 0; k < 4 && rq.size() > 0; k++) begin
      r = rq.pop_front();
      checkOutput("t5_rdata", r.data, t2d[k]);
    end
    waitB(1);
    if (bq.size() > 0) begin b = bq.pop_front(); checkOutput("t5_bid", b.id, 4'd9); end
    sendAr(4'd8, 8'd3, 2'b01, 32'h180, c2);
    waitR(4);
    for (int k = 0; k < 4 && rq.size() > 0; k++) begin
      r = rq.pop_front();
      checkOutput("t5_readback", r.data, t5d[k]);
    end
    rnd_mode = 1'b0;
    sync();

    // Reset during beat 2 of an 8-beat read
    sendAr(4'd1, 8'd7, 2'b01, 32'h1F0, c2);
    sync();
    sync();
    rst_wr = 1'b1;
    @(negedge clk_wr);
    checkOutput("t6_rvalid_in_reset", user.rvalid, 1'b0);
    sync();
    rst_wr = 1'b0;
    @(negedge clk_wr);
    checkOutput("t6_arready_after", user.arready, 1'b1);
    checkOutput("t6_rd_cnt_cleared", rd_burst_cnt, 16'd0);
    sync();
    rq.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_wr = 1'b1;
    user.arid = '0; user.arsize = '0; user.arlen = '0; user.arburst = '0; user.araddr = '0;
    user.arvalid = 1'b0;
    user.awid = '0; user.awsize = '0; user.awlen = '0; user.awburst = '0; user.awaddr = '0;
    user.awvalid = 1'b0;
    user.wid = '0; user.wdata = '0; user.wstrb = '0; user.wlast = 1'b0; user.wvalid = 1'b0;
    user.rready = 1'b1; user.bready = 1'b1;
    repeat (3) @(posedge clk_wr);
    #1;
    rst_wr = 1'b0;
    @(negedge clk_wr);
    checkOutput("reset_bid",   user.bid,   4'd0);
    checkOutput("reset_bresp", user.bresp, 2'b00);
    checkOutput("reset_rid",   user.rid,   4'd0);
    checkOutput("reset_rresp", user.rresp, 2'b00);
    checkOutput("reset_rlast", user.rlast, 1'b0);
    sync();
    applyStimulus();
    repeat (3) sync();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aximm_follower_mem_responder.md
# aximm_follower_mem_responder

Byte-strobed memory responder that terminates the AXI-MM follower user interface (the F_user_* channels) in loopback and throughput benches. It accepts AW/W bursts into a local word array and returns B responses. It serves AR bursts from the same array on R. It sits directly downstream of the follower: its AR/AW/W inputs are the follower's outputs, and its R/B outputs feed the follower's R/B inputs.

## Interface
- DATA_WIDTH, 64: R/W data width in bits; multiple of 64, at most 128.
- MEM_AW, 6: log2 of memory depth in DATA_WIDTH-bit words.
- clk_wr  in  1  sole clock; all logic is on its rising edge.
- rst_wr  in  1  synchronous, active-high reset.
- user_arid/arsize/arlen/arburst/araddr  in  4/3/8/2/32  read address.
- user_arvalid  in  1; user_arready  out  1.
- user_awid/awsize/awlen/awburst/awaddr  in  4/3/8/2/32  write address.
- user_awvalid  in  1; user_awready  out  1.
- user_wid/wdata/wstrb/wlast  in  4/DATA_WIDTH/16/1  write data; wid is ignored.
- user_wvalid  in  1; user_wready  out  1.
- user_rid/rdata/rlast/rresp  out  4/DATA_WIDTH/1/2  read data.
- user_rvalid  out  1; user_rready  in  1.
- user_bid/bresp  out  4/2; user_bvalid  out  1; user_bready  in  1.
- wr_burst_cnt  out  16  completed B handshakes; wraps at 16'hFFFF->0.
- rd_burst_cnt  out  16  completed last-beat R handshakes; wraps at 16'hFFFF->0.
- err_cnt  out  8  SLVERR responses issued; saturates at 8'hFF.

## Operation
- Word index:
  - BW = log2(DATA_WIDTH/8).
  - The word index is addr[MEM_AW+BW-1:BW]; all other address bits are ignored.
  - arsize/awsize are ignored; every beat is full width.
- Burst address:
  - FIXED (2'b00): the index holds for every beat.
  - INCR (2'b01) and WRAP (2'b10): the index increments by 1 per beat, modulo 2^MEM_AW, so it rolls over at the top of the array.
  - Reserved (2'b11): behaves as INCR, and the burst response is SLVERR.
- Write FSM, states WR_IDLE, WR_DATA, WR_RESP:
  - WR_IDLE: awready=1. On an AW handshake, capture id, len, burst and start index, clear the beat counter, and go to WR_DATA.
  - WR_DATA: wready=1. Each W handshake writes the byte lanes where wstrb[i]=1, for i < DATA_WIDTH/8; wstrb bits above that are ignored. The index advances and the beat counter increments.
  - The burst ends on whichever comes first: the handshake with wlast=1, or the handshake where beat == awlen. Then go to WR_RESP.
  - bresp=SLVERR (2'b10) if the wlast position disagrees with awlen, or if the burst was reserved. Otherwise bresp=OKAY (2'b00).
  - WR_RESP: bvalid=1, bid = captured id. bid and bresp stay stable until bready. On the B handshake, go to WR_IDLE.
- Read FSM, states RD_IDLE, RD_DATA:
  - RD_IDLE: arready=1. On an AR handshake, capture the burst fields and go to RD_DATA.
  - RD_DATA: rvalid=1, rdata = array[index] read combinationally, rid = captured id.
  - rlast=1 when beat == arlen. rresp=SLVERR for a reserved burst, otherwise OKAY.
  - Each R handshake advances the beat. The handshake with rlast=1 returns the FSM to RD_IDLE.
  - rdata, rid, rlast and rresp are stable while rvalid=1 and rready=0.
- Channel independence:
  - The read and write FSMs run fully independently; AR and AW may both handshake in the same cycle.
  - If a read and a write hit the same word in one cycle, R returns the pre-write contents; the write is visible from the next cycle.
- Reset:
  - All *ready and *valid outputs are 0 while rst_wr=1.
  - Both FSMs reset to IDLE, and all counters reset to 0.
  - rid, bid, rresp and bresp reset to 0; rlast resets to 0.
  - The memory array is not cleared by reset.
  - Asserting reset mid-burst abandons the burst: no B or R is issued, and partial writes already made remain in the array.

## Timing
- AW handshake in cycle N: wready=1 from N+1.
- Last W handshake in cycle M: bvalid=1 from M+1. After the B handshake in cycle K, awready=1 from K+1.
- AR handshake in cycle N: rvalid=1 from N+1, with one beat per cycle while rready=1.
- After the last R handshake in cycle K, arready=1 from K+1.
- Sustained throughput: one burst per len+3 cycles on writes, and one per len+2 cycles on reads.

## Structure
- Shared package aximm_resp_pkg holds:
  - resp constants OKAY and SLVERR;
  - burst constants FIXED, INCR, WRAP;
  - enums wr_state_t and rd_state_t.
- Sub-module aximm_mem_bank: a 2^MEM_AW x DATA_WIDTH array with a byte-strobed synchronous write port and one combinational read port.
- Both FSMs, the address generators and the counters live in the top module.

## Test plan
- Single-beat write then read:
  - Stimulus: AW addr=0x40, len=0, INCR, id=3; W wdata=0xA5A5..., wstrb=0xFF, wlast=1. Then AR addr=0x40, len=0, id=5.
  - Response: B id=3, OKAY. R id=5, the same data, rlast=1, OKAY. wr_burst_cnt=1 and rd_burst_cnt=1.
- INCR rollover:
  - Stimulus: 4-beat write (len=3) starting at word 62, then a matching 4-beat read.
  - Response: words 62, 63, 0, 1 are written and read back in that order.
- Partial strobe and FIXED burst:
  - Stimulus: write 0xFF..FF to word 5, then a 2-beat FIXED write with wstrb=0x0F, data 0x11 then 0x22 (replicated across the beat).
  - Response: the word reads back with low 4 bytes 0x22222222 and high bytes 0xFF.
- Protocol error:
  - Stimulus: awlen=3 with wlast asserted on beat 1.
  - Response: B is SLVERR after 2 beats; err_cnt=1.
  - Stimulus: AR with arburst=2'b11.
  - Response: every R beat is SLVERR.
- Backpressure and concurrency:
  - Stimulus: random rready/bready at 50% duty; AR and AW issued in the same cycle.
  - Response: both are accepted the same cycle, R/B payloads stay stable while stalled, and the data is correct.
- Reset mid-burst:
  - Stimulus: assert rst_wr during beat 2 of an 8-beat read.
  - Response: rvalid=0 in the reset cycle, and arready=1 the cycle after rst_wr deasserts.
